// File: rtl/multi_channel_packet_sink.sv
// NCH-channel NoC packet sink: per-channel handshake with backward stall, receive counters,
// last-packet capture and destination-address checking. Optional STAMP_EN adds cycle stamps.
module multi_channel_packet_sink #(
  parameter int WIDTH_PACKET = 14,
  parameter int NCH          = 4,
  parameter int ADDR_W       = 3,
  parameter int NODE_ADDR    = 0,
  parameter int BL           = 0,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              in_valid,
  output logic [NCH-1:0]              in_ready,
  input  logic [NCH*WIDTH_PACKET-1:0] in_data,
  input  logic                        clr,
  output logic [NCH*CNT_W-1:0]        rx_count,
  output logic [NCH*WIDTH_PACKET-1:0] last_data,
  output logic [CNT_W-1:0]            err_count,
  output logic                        err_flag
`ifdef STAMP_EN
  ,
  output logic [NCH*CNT_W-1:0]        last_stamp
`endif
);

  typedef enum logic {READY, STALL} chState_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               STALL_EN   = (BL > 0);
  localparam logic [7:0]       STALL_INIT = 8'((BL > 0) ? (BL - 1) : 0);
  localparam int               POP_W      = $clog2(NCH + 1);
  localparam int               SUM_W      = CNT_W + POP_W;

  logic [NCH-1:0] handshake;
  logic [NCH-1:0] mismatch;

`ifdef STAMP_EN
  logic [CNT_W-1:0] cycleReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleReg <= '0;
    end else begin
      cycleReg <= cycleReg + CNT_W'(1);
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : gChan
      chState_e                stateReg, stateNext;
      logic [7:0]              stallReg, stallNext;
      logic [CNT_W-1:0]        rxReg;
      logic [WIDTH_PACKET-1:0] lastReg;
      logic [WIDTH_PACKET-1:0] pkt;
      logic [ADDR_W-1:0]       destAddr;
      logic [ADDR_W-1:0]       expAddr;

      assign pkt      = in_data[gi*WIDTH_PACKET +: WIDTH_PACKET];
      assign destAddr = pkt[WIDTH_PACKET-1 -: ADDR_W];
      assign expAddr  = ADDR_W'(NODE_ADDR + gi);

      // Ready is masked by reset combinationally so no packet is consumed while held.
      assign in_ready[gi]  = (stateReg == READY) && !reset;
      assign handshake[gi] = in_valid[gi] && in_ready[gi];
      assign mismatch[gi]  = handshake[gi] && (destAddr != expAddr);

      always_comb begin
        stateNext = stateReg;
        stallNext = stallReg;
        case (stateReg)
          READY: begin
            if (handshake[gi] && STALL_EN) begin
              stateNext = STALL;
              stallNext = STALL_INIT;
            end
          end
          STALL: begin
            if (stallReg == 8'd0) begin
              stateNext = READY;
            end else begin
              stallNext = stallReg - 8'd1;
            end
          end
          default: stateNext = READY;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stateReg <= READY;
          stallReg <= '0;
          rxReg    <= '0;
          lastReg  <= '0;
        end else begin
          stateReg <= stateNext;
          stallReg <= stallNext;
          if (handshake[gi]) begin
            lastReg <= pkt;
          end
          if (clr) begin
            rxReg <= '0;
          end else if (handshake[gi] && (rxReg != CNT_MAX)) begin
            rxReg <= rxReg + CNT_W'(1);
          end
        end
      end

      assign rx_count[gi*CNT_W +: CNT_W]                = rxReg;
      assign last_data[gi*WIDTH_PACKET +: WIDTH_PACKET] = lastReg;

`ifdef STAMP_EN
      logic [CNT_W-1:0] stampReg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stampReg <= '0;
        end else if (handshake[gi]) begin
          stampReg <= cycleReg;
        end
      end

      assign last_stamp[gi*CNT_W +: CNT_W] = stampReg;

`ifndef SYNTHESIS
      always @(posedge clk) begin
        if (!reset && handshake[gi]) begin
          $display("sink ch %0d cycle %0d packet %h", gi, cycleReg, pkt);
        end
      end
`endif
`endif
    end
  endgenerate

  logic [POP_W-1:0] errInc;
  logic [SUM_W-1:0] errSum;
  logic [CNT_W-1:0] errReg;
  logic             flagReg;

  always_comb begin
    errInc = '0;
    for (int i = 0; i < NCH; i++) begin
      errInc = errInc + POP_W'(mismatch[i]);
    end
  end

  // Widened sum so several mismatches in one cycle saturate rather than wrap.
  assign errSum = {{POP_W{1'b0}}, errReg} + SUM_W'(errInc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errReg  <= '0;
      flagReg <= 1'b0;
    end else if (clr) begin
      errReg  <= '0;
      flagReg <= 1'b0;
    end else if (mismatch != '0) begin
      flagReg <= 1'b1;
      if (errSum > SUM_W'(CNT_MAX)) begin
        errReg <= CNT_MAX;
      end else begin
        errReg <= errSum[CNT_W-1:0];
      end
    end
  end

  assign err_count = errReg;
  assign err_flag  = flagReg;

endmodule

// File: tb/tb_multi_channel_packet_sink.sv
// Scoreboarded bench for multi_channel_packet_sink: three instances with different BL/CNT_W/NODE_ADDR.
module tb_multi_channel_packet_sink;

  logic        clk;
  logic        reset;
  logic        clr;
  logic [3:0]  vA, vB, vC;
  logic [3:0]  rdyA, rdyB, rdyC;
  logic [55:0] dA, dB, dC;
  logic [15:0] rxA;
  logic [63:0] rxB, rxC;
  logic [55:0] ldA, ldB, ldC;
  logic [3:0]  errA;
  logic [15:0] errB, errC;
  logic        flagA, flagB, flagC;
`ifdef STAMP_EN
  logic [15:0] stA;
  logic [63:0] stB, stC;
`endif

  multi_channel_packet_sink #(.WIDTH_PACKET(14), .NCH(4), .ADDR_W(3), .NODE_ADDR(0), .BL(0), .CNT_W(4)) dutA (
    .clk(clk), .reset(reset), .in_valid(vA), .in_ready(rdyA), .in_data(dA), .clr(clr),
    .rx_count(rxA), .last_data(ldA), .err_count(errA), .err_flag(flagA)
`ifdef STAMP_EN
    , .last_stamp(stA)
`endif
  );

  multi_channel_packet_sink #(.WIDTH_PACKET(14), .NCH(4), .ADDR_W(3), .NODE_ADDR(6), .BL(2), .CNT_W(16)) dutB (
    .clk(clk), .reset(reset), .in_valid(vB), .in_ready(rdyB), .in_data(dB), .clr(clr),
    .rx_count(rxB), .last_data(ldB), .err_count(errB), .err_flag(flagB)
`ifdef STAMP_EN
    , .last_stamp(stB)
`endif
  );

  multi_channel_packet_sink #(.WIDTH_PACKET(14), .NCH(4), .ADDR_W(3), .NODE_ADDR(0), .BL(3), .CNT_W(16)) dutC (
    .clk(clk), .reset(reset), .in_valid(vC), .in_ready(rdyC), .in_data(dC), .clr(clr),
    .rx_count(rxC), .last_data(ldC), .err_count(errC), .err_flag(flagC)
`ifdef STAMP_EN
    , .last_stamp(stC)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    int          ch;
    logic [13:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [13:0] mkPkt(input logic [2:0] dest, input logic [10:0] payload);
    return {dest, payload};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic rdyOf(input int inst, input int ch);
    case (inst)
      0:       return rdyA[ch];
      1:       return rdyB[ch];
      default: return rdyC[ch];
    endcase
  endfunction

  // Presents a packet and holds it until accepted; the expected capture goes to the scoreboard.
  task automatic send(input int inst, input int ch, input logic [13:0] data, output int waits);
    waits = 0;
    case (inst)
      0:       begin vA[ch] = 1'b1; dA[ch*14 +: 14] = data; end
      1:       begin vB[ch] = 1'b1; dB[ch*14 +: 14] = data; end
      default: begin vC[ch] = 1'b1; dC[ch*14 +: 14] = data; end
    endcase
    while (!rdyOf(inst, ch) && waits < 20) begin
      tick();
      waits++;
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst %0d ch %0d: ready never seen within %0d cycles", inst, ch, waits);
    end else begin
      sbq.push_back('{inst, ch, data});
      tick();
    end
  endtask

  // Monitor: each handshake seen before an edge is checked against the scoreboard after it.
  initial begin
    logic [3:0]  hs [3];
    logic [13:0] act;
    exp_t        e;
    hs[0] = '0; hs[1] = '0; hs[2] = '0;
    forever begin
      @(negedge clk);
      for (int inst = 0; inst < 3; inst++) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (hs[inst][ch]) begin
            act = (inst == 0) ? ldA[ch*14 +: 14] : (inst == 1) ? ldB[ch*14 +: 14] : ldC[ch*14 +: 14];
            checks++;
            if (sbq.size() == 0) begin
              errors++;
              $display("FAIL unexpected_handshake inst %0d ch %0d: got packet %h expected none", inst, ch, act);
            end else begin
              e = sbq.pop_front();
              if (e.inst != inst || e.ch != ch || act !== e.data) begin
                errors++;
                $display("FAIL last_data inst %0d ch %0d: got %h expected inst %0d ch %0d %h",
                         inst, ch, act, e.inst, e.ch, e.data);
              end else begin
                $display("ok   last_data inst %0d ch %0d: %h", inst, ch, act);
              end
            end
          end
        end
      end
      hs[0] = vA & rdyA;
      hs[1] = vB & rdyB;
      hs[2] = vC & rdyC;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int maxW;
    int n;
    logic rdy;
    reset = 1'b1;
    clr   = 1'b0;
    vA = '0; vB = '0; vC = '0;
    dA = '0; dB = '0; dC = '0;
    tick();
    tick();
    chk("reset_readyA", rdyA, 4'h0);
    chk("reset_readyB", rdyB, 4'h0);
    chk("reset_readyC", rdyC, 4'h0);
    chk("reset_rxA", rxA, 16'h0);
    chk("reset_lastA", ldA, 56'h0);
    chk("reset_errA", errA, 4'h0);
    chk("reset_flagA", flagA, 1'b0);
    reset = 1'b0;
    #1;
    chk("release_readyA", rdyA, 4'hF);
    chk("release_readyB", rdyB, 4'hF);

    // Handshake coinciding with clr: packet captured but not counted.
    repeat (7) tick();
    clr = 1'b1;
    send(0, 0, mkPkt(3'd0, 11'h7A5), w);
    clr = 1'b0;
    vA = '0;
    chk("clr_hs_rx0", rxA[3:0], 4'd0);
`ifdef STAMP_EN
    chk("stamp_ch0", stA[3:0], 4'd7);
`endif

    // Back-to-back packets with BL=0.
    maxW = 0;
    for (int i = 0; i < 10; i++) begin
      send(0, 0, mkPkt(3'd0, 11'(i + 1)), w);
      if (w > maxW) maxW = w;
    end
    vA = '0;
    chk("t1_ready_waits", 64'(maxW), 64'd0);
    chk("t1_rx0", rxA[3:0], 4'd10);
    chk("t1_err", errA, 4'd0);

    // Saturation of the 4-bit receive counter, then clear.
    for (int i = 0; i < 10; i++) send(0, 0, mkPkt(3'd0, 11'(i + 16'h100)), w);
    vA = '0;
    chk("t4_rx0_sat", rxA[3:0], 4'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_rx0_clr", rxA[3:0], 4'd0);

    // Two simultaneous wrong destinations.
    vA[2] = 1'b1; dA[2*14 +: 14] = mkPkt(3'd5, 11'h111);
    vA[3] = 1'b1; dA[3*14 +: 14] = mkPkt(3'd0, 11'h222);
    sbq.push_back('{0, 2, mkPkt(3'd5, 11'h111)});
    sbq.push_back('{0, 3, mkPkt(3'd0, 11'h222)});
    chk("t3_flag_before", flagA, 1'b0);
    tick();
    vA = '0;
    chk("t3_err2", errA, 4'd2);
    chk("t3_flag", flagA, 1'b1);
    chk("t3_rx2", rxA[11:8], 4'd1);
    chk("t3_rx3", rxA[15:12], 4'd1);
    repeat (3) tick();
    send(0, 1, mkPkt(3'd1, 11'h333), w);
    vA = '0;
    chk("t3_err_good", errA, 4'd2);
    chk("t3_flag_sticky", flagA, 1'b1);
    chk("t3_rx1", rxA[7:4], 4'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_err_clr", errA, 4'd0);
    chk("t3_flag_clr", flagA, 1'b0);

    // All four channels wrong every cycle: 4,8,12 then saturate at 15.
    for (int c = 0; c < 4; c++) begin
      vA = 4'hF;
      for (int ch = 0; ch < 4; ch++) begin
        dA[ch*14 +: 14] = mkPkt(3'd7, 11'(16 * c + ch));
        sbq.push_back('{0, ch, mkPkt(3'd7, 11'(16 * c + ch))});
      end
      tick();
      if (c == 2) chk("sat_err12", errA, 4'd12);
    end
    vA = '0;
    chk("sat_err15", errA, 4'd15);
    chk("sat_rx0", rxA[3:0], 4'd4);

    // BL=2 continuous valid on ch1: ready 1,0,0 repeating.
    vB[1] = 1'b1;
    dB[1*14 +: 14] = mkPkt(3'd7, 11'h40);
    for (int i = 0; i < 9; i++) begin
      rdy = rdyB[1];
      chk($sformatf("t2_ready_c%0d", i), rdy, (i % 3 == 0));
      if (rdy) sbq.push_back('{1, 1, dB[1*14 +: 14]});
      tick();
      if (rdy) dB[1*14 +: 14] = mkPkt(3'd7, 11'(16'h41 + i));
    end
    vB = '0;
    chk("t2_rx1", rxB[31:16], 16'd3);
    chk("t2_err", errB, 16'd0);

    // NODE_ADDR=6: ch2 expects 0 and ch3 expects 1 after wrap; ch0 expects 6.
    send(1, 2, mkPkt(3'd0, 11'h2A), w); vB = '0;
    send(1, 3, mkPkt(3'd1, 11'h3B), w); vB = '0;
    chk("wrap_err_good", errB, 16'd0);
    send(1, 0, mkPkt(3'd7, 11'h0C), w); vB = '0;
    chk("wrap_err_bad", errB, 16'd1);
    chk("wrap_flag", flagB, 1'b1);

    // BL=3 stall length.
    send(2, 1, mkPkt(3'd1, 11'h77), w);
    vC = '0;
    n = 0;
    while (!rdyC[1] && n < 10) begin
      tick();
      n++;
    end
    chk("bl3_stall_cycles", 64'(n), 64'd3);

    // Reset asserted mid-STALL.
    send(2, 0, mkPkt(3'd0, 11'h55), w);
    vC = '0;
    chk("t5_stall_ready", rdyC[0], 1'b0);
    tick();
    chk("t5_still_stall", rdyC[0], 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_reset_readyC", rdyC, 4'h0);
    tick();
    tick();
    chk("t5_reset_rxC", rxC, 64'h0);
    chk("t5_reset_lastC", ldC, 56'h0);
    reset = 1'b0;
    #1;
    chk("t5_release_readyC", rdyC, 4'hF);
    chk("t5_release_errC", errC, 16'd0);
    chk("t5_release_rxA", rxA, 16'h0);

    tick();
    tick();
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
